// File: rtl/vec_issue_ctrl_pkg.sv
// Shared definitions for the vector-side issue controller.
// Holds the FSM state encodings and the default execution timeout.
// Imported by vec_issue_ctrl; no logic lives here.
package vec_issue_ctrl_pkg;

    // Issue FSM state encodings (2 bits).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Default number of EXEC cycles before a forced error response.
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage : vec_issue_ctrl_pkg

// File: rtl/vec_issue_ctrl.sv
// Purpose: vector-side responder for the scalar<->vector valid/ready/ack issue handshake.
// Latency: capture at edge N -> issue_valid in N+1 -> earliest ack in N+2 -> ready again in N+3.
// Backpressure: ack/err held in RESP until scalar_pro_ready; inst_valid ignored outside IDLE.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   inst_valid/instruction/rs1/rs2     instruction offer from the scalar core
//   vec_pro_ready                      high in IDLE: an offer will be captured
//   vec_pro_ack/vec_pro_err            response (retire) and its error qualifier
//   scalar_pro_ready                   scalar core takes the response
//   inst_o/rs1_o/rs2_o                 latched instruction and operands
//   issue_valid                        one-cycle start pulse to the datapath
//   is_vec                             decoder legality of inst_o, sampled in ISSUE
//   exec_done                          datapath completion pulse
//   exec_cycles                        EXEC cycles spent by the last instruction
module vec_issue_ctrl
    import vec_issue_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_valid,
    input  logic [XLEN-1:0]  instruction,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             scalar_pro_ready,
    output logic             vec_pro_ready,
    output logic             vec_pro_ack,
    output logic             vec_pro_err,
    output logic [XLEN-1:0]  inst_o,
    output logic [XLEN-1:0]  rs1_o,
    output logic [XLEN-1:0]  rs2_o,
    output logic             issue_valid,
    input  logic             is_vec,
    input  logic             exec_done,
    output logic [CNT_W-1:0] exec_cycles
);

    // Counter value in the last EXEC cycle allowed before timing out.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] exec_cycles_q, exec_cycles_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: a stuck datapath must never wrap the count back to zero.
    always_comb begin
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        inst_d        = inst_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        cnt_d         = cnt_q;
        exec_cycles_d = exec_cycles_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (inst_valid) begin
                    inst_d  = instruction;
                    rs1_d   = rs1_data;
                    rs2_d   = rs2_data;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d = '0;
                if (!is_vec) begin
                    // Illegal instruction never reaches the datapath.
                    err_d         = 1'b1;
                    exec_cycles_d = '0;
                    state_d       = ST_RESP;
                end else if (exec_done) begin
                    // Single-cycle op completes without spending a cycle in EXEC.
                    err_d         = 1'b0;
                    exec_cycles_d = '0;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                cnt_d = cnt_inc;
                // exec_done is checked first so a completion on the timeout cycle is not an error.
                if (exec_done) begin
                    err_d         = 1'b0;
                    exec_cycles_d = cnt_inc;
                    state_d       = ST_RESP;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    err_d         = 1'b1;
                    exec_cycles_d = cnt_inc;
                    state_d       = ST_RESP;
                end
            end

            default: begin // ST_RESP
                if (scalar_pro_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            err_q         <= 1'b0;
            inst_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            cnt_q         <= '0;
            exec_cycles_q <= '0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            inst_q        <= inst_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            cnt_q         <= cnt_d;
            exec_cycles_q <= exec_cycles_d;
        end
    end

    // Moore decodes of the registered state.
    assign vec_pro_ready = (state_q == ST_IDLE);
    assign issue_valid   = (state_q == ST_ISSUE);
    assign vec_pro_ack   = (state_q == ST_RESP);
    assign vec_pro_err   = (state_q == ST_RESP) && err_q;
    assign inst_o        = inst_q;
    assign rs1_o         = rs1_q;
    assign rs2_o         = rs2_q;
    assign exec_cycles   = exec_cycles_q;

endmodule : vec_issue_ctrl

// File: tb/tb_vec_issue_ctrl.sv
// Purpose: self-checking bench for vec_issue_ctrl (directed vectors plus corner sequences).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on the following negedge.
// Backpressure: exercised by holding scalar_pro_ready low in RESP.
module tb_vec_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] instruction, rs1_data, rs2_data;
    logic        scalar_pro_ready;
    logic        vec_pro_ready, vec_pro_ack, vec_pro_err;
    logic [31:0] inst_o, rs1_o, rs2_o;
    logic        issue_valid;
    logic        is_vec, exec_done;
    logic [15:0] exec_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_issue_ctrl #(
        .XLEN(32),
        .TIMEOUT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_valid(inst_valid),
        .instruction(instruction),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .scalar_pro_ready(scalar_pro_ready),
        .vec_pro_ready(vec_pro_ready),
        .vec_pro_ack(vec_pro_ack),
        .vec_pro_err(vec_pro_err),
        .inst_o(inst_o),
        .rs1_o(rs1_o),
        .rs2_o(rs2_o),
        .issue_valid(issue_valid),
        .is_vec(is_vec),
        .exec_done(exec_done),
        .exec_cycles(exec_cycles)
    );

    // One cycle of stimulus and the Moore outputs expected in that same cycle.
    typedef struct {
        logic        iv;
        logic [31:0] ins, r1, r2;
        logic        isv, done, srdy;
        logic        e_rdy, e_ack, e_err, e_iss;
        logic [31:0] e_inst, e_rs1, e_rs2;
        logic [15:0] e_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Checks the four handshake outputs as one comparison.
    task automatic hs(input string name, input logic rdy, input logic ack, input logic err, input logic iss);
        chk(name, {124'd0, vec_pro_ready, vec_pro_ack, vec_pro_err, issue_valid},
                  {124'd0, rdy, ack, err, iss});
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic isv, input logic done, input logic srdy);
        inst_valid       = iv;
        instruction      = ins;
        rs1_data         = r1;
        rs2_data         = r2;
        is_vec           = isv;
        exec_done        = done;
        scalar_pro_ready = srdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Config handshake: vsetvli, single-cycle completion in ISSUE.
        vecs[0] = '{1'b1, 32'h01007057, 32'd16, 32'd0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'd0};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h01007057, 32'd16, 32'd0, 16'd0};
        vecs[2] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h01007057, 32'd16, 32'd0, 16'd0};
        vecs[3] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h01007057, 32'd16, 32'd0, 16'd0};
        // Illegal instruction: straight to RESP with err, no EXEC.
        vecs[4] = '{1'b1, 32'h00000013, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h01007057, 32'd16, 32'd0, 16'd0};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'd5, 32'd7, 16'd0};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b1, 1'b0, 32'h00000013, 32'd5, 32'd7, 16'd0};
        vecs[7] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h00000013, 32'd5, 32'd7, 16'd0};

        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) next_cycle();

        // Reset state.
        @(negedge clk);
        hs("reset_hs", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_data", {inst_o, rs1_o, rs2_o, 16'd0, exec_cycles}, 128'd0);
        next_cycle();
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].iv, vecs[i].ins, vecs[i].r1, vecs[i].r2,
                  vecs[i].isv, vecs[i].done, vecs[i].srdy);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {vec_pro_ready, vec_pro_ack, vec_pro_err, issue_valid,
                 inst_o, rs1_o, rs2_o, exec_cycles},
                {vecs[i].e_rdy, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_iss,
                 vecs[i].e_inst, vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_cyc});
            next_cycle();
        end

        // Multi-cycle load: exec_done arrives 5 cycles after issue.
        drive(1'b1, 32'h02006007, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); hs("ld_accept", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); hs("ld_issue", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        for (int k = 1; k <= 5; k++) begin
            exec_done = (k == 5);
            @(negedge clk); hs($sformatf("ld_exec%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        exec_done = 1'b0;
        @(negedge clk);
        hs("ld_ack", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ld_exec_cycles", {112'd0, exec_cycles}, 128'd5);

        // Backpressure: 7 cycles without scalar_pro_ready, with a competing offer.
        drive(1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            hs($sformatf("bp_hold%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("bp_inst%0d", k), {96'd0, inst_o}, {96'd0, 32'h02006007});
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        scalar_pro_ready = 1'b0;
        @(negedge clk);
        hs("bp_idle", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_no_capture", {64'd0, inst_o, rs1_o}, {64'd0, 32'h02006007, 32'h1000});
        next_cycle();

        // Timeout: no exec_done, 8 EXEC cycles then error response.
        drive(1'b1, 32'h0200E007, 32'h2000, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); hs("to_issue", 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); hs($sformatf("to_exec%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        exec_done = 1'b1;       // late pulse in RESP must be ignored
        @(negedge clk);
        hs("to_ack", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("to_exec_cycles", {112'd0, exec_cycles}, 128'd8);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); hs("to_ack_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0); // late pulse in IDLE
        @(negedge clk); hs("to_idle", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        exec_done = 1'b0;
        @(negedge clk); hs("to_idle_after", 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();

        // Reset while in EXEC drops the instruction.
        drive(1'b1, 32'h02008087, 32'h3000, 32'h4, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle();
        next_cycle();
        @(negedge clk); hs("rst_in_exec", 1'b0, 1'b0, 1'b0, 1'b0);
        reset     = 1'b1;
        exec_done = 1'b1;
        next_cycle();
        reset     = 1'b0;
        exec_done = 1'b0;
        @(negedge clk);
        hs("rst_after", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_after_data", {inst_o, rs1_o, rs2_o, 16'd0, exec_cycles}, 128'd0);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            exec_done = (k == 2);
            @(negedge clk);
            hs($sformatf("rst_quiet%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vec_issue_ctrl

// File: doc/vec_issue_ctrl.md
Name: vec_issue_ctrl

Overview:
- Vector-side responder for the scalar↔vector valid/ready/ack issue protocol; the counterpart of the scalar processor's issue logic.
- Accepts one instruction with its rs1/rs2 operands when `inst_valid` and `vec_pro_ready` are both high, and latches them.
- Presents the latched instruction to the decoder/datapath and tracks execution.
- Raises `vec_pro_ack` until the scalar processor accepts the response; sits between the top-level ports of `vector_processor` and its decode/datapath.

Parameters:
- XLEN, 32, width of instruction and scalar operands
- TIMEOUT_CYCLES, 1024, maximum cycles in EXEC before forced error response
- CNT_W, 16, width of per-instruction execution-cycle counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_valid  in  1  scalar: instruction/operands valid
- instruction  in  XLEN  scalar: instruction word
- rs1_data  in  XLEN  scalar: rs1 operand
- rs2_data  in  XLEN  scalar: rs2 operand
- scalar_pro_ready  in  1  scalar ready to take response
- vec_pro_ready  out  1  controller can accept an instruction
- vec_pro_ack  out  1  response valid (instruction retired)
- vec_pro_err  out  1  qualifies ack: illegal instruction or timeout
- inst_o  out  XLEN  latched instruction to decoder
- rs1_o  out  XLEN  latched rs1
- rs2_o  out  XLEN  latched rs2
- issue_valid  out  1  one-cycle start pulse to datapath
- is_vec  in  1  decoder legality of inst_o (combinational, valid in ISSUE)
- exec_done  in  1  datapath/LSU: instruction complete (pulse)
- exec_cycles  out  CNT_W  cycles spent in EXEC for last instruction

Behaviour:
- Decided: one clock `clk`; `reset` synchronous, active-high. Priority over all other inputs.
- Reset values:
  - state=IDLE, vec_pro_ready=1, vec_pro_ack=0, vec_pro_err=0, issue_valid=0.
  - inst_o=0, rs1_o=0, rs2_o=0, exec_cycles=0, timeout counter=0.
- Reset mid-operation: the in-flight instruction is dropped, no ack is produced, and the next cycle is IDLE.
- Outputs are Moore decodes of the registered state.
- States:
  - IDLE: vec_pro_ready=1. On a cycle with inst_valid=1, capture instruction/rs1_data/rs2_data into inst_o/rs1_o/rs2_o and move to ISSUE. Clear the cycle counter.
  - ISSUE: issue_valid=1 for exactly one cycle, vec_pro_ready=0.
    - is_vec=0 → RESP with err=1.
    - else exec_done=1 (single-cycle op) → RESP with err=0.
    - else → EXEC.
  - EXEC: counter increments each cycle.
    - exec_done=1 → RESP with err=0; exec_cycles latches the count.
    - count reaches TIMEOUT_CYCLES-1 without exec_done → RESP with err=1.
    - exec_done and timeout in the same cycle → exec_done wins (err=0).
  - RESP: vec_pro_ack=1 and vec_pro_err held stable until a cycle with scalar_pro_ready=1. On that edge, go to IDLE and drop ack.
- Handshake rules:
  - scalar_pro_ready may be asserted before RESP; ack and ready high in the same cycle completes in that cycle.
  - inst_valid is ignored outside IDLE; no new capture until back in IDLE.
  - exec_done outside ISSUE/EXEC is ignored.
- Latency: accept at edge N → issue_valid in cycle N+1 → earliest ack in cycle N+2 → earliest next vec_pro_ready in cycle N+3.
- Widths:
  - Counter saturates at 2^CNT_W-1, with no wrap.
  - inst_o/rs*_o hold their value after ack until the next capture.

Decomposition:
- Add to `vector_processor_defs.svh`:
  - `issue_state_e` enum {IDLE, ISSUE, EXEC, RESP}, 2 bits.
  - Default-TIMEOUT define.
- No sub-module is required; the timeout/cycle counter stays inline as one always_ff.
- The block is instantiated inside `vector_processor` in place of the existing handshake glue.

Test Plan:
- Config handshake:
  - Stimulus: reset, then inst_valid=1 with instruction=0x01007057 (vsetvli e32), rs1_data=16; is_vec=1, exec_done pulsed in ISSUE; scalar_pro_ready=1.
  - Required: issue_valid high for exactly one cycle; ack at N+2 with err=0; inst_o=0x01007057, rs1_o=16; vec_pro_ready high again at N+3.
- Multi-cycle load:
  - Stimulus: exec_done returned 5 cycles after issue.
  - Required: ack asserted the cycle after exec_done; exec_cycles=5.
- Backpressure:
  - Stimulus: scalar_pro_ready held 0 for 7 cycles in RESP.
  - Required: ack and err stable all 7 cycles; vec_pro_ready=0; a new inst_valid is not captured (inst_o unchanged).
- Illegal instruction:
  - Stimulus: instruction=0x00000013 with is_vec=0.
  - Required: no transition to EXEC; ack with err=1 at N+2.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8 with no exec_done.
  - Required: ack with err=1 after 8 EXEC cycles; a late exec_done pulse during RESP/IDLE is ignored.
- Reset mid-EXEC:
  - Stimulus: assert reset for one cycle while in EXEC.
  - Required: next cycle shows vec_pro_ready=1, ack=0, inst_o=0, and no spurious ack afterwards.
